// File: rtl/uncache_pkg.sv
// Shared types and helpers for the uncached access unit.
// Holds the FSM state encoding, AXI size codes and the byte-enable to size mapping.
package uncache_pkg;

  typedef enum logic [2:0] {
    ST_IDLE    = 3'd0,
    ST_WR_REQ  = 3'd1,
    ST_WR_RESP = 3'd2,
    ST_RD_REQ  = 3'd3,
    ST_RD_DONE = 3'd4
  } state_t;

  localparam logic [2:0] SIZE_1B   = 3'd0;
  localparam logic [2:0] SIZE_2B   = 3'd1;
  localparam logic [2:0] SIZE_4B   = 3'd2;
  localparam logic [2:0] SIZE_8B   = 3'd3;
  localparam logic [2:0] SIZE_16B  = 3'd4;
  localparam logic [2:0] SIZE_32B  = 3'd5;
  localparam logic [2:0] SIZE_64B  = 3'd6;
  localparam logic [2:0] SIZE_128B = 3'd7;

  localparam int unsigned MAX_BE_W  = 128;
  localparam int unsigned BE_IDX_W  = $clog2(MAX_BE_W);

  // Map a byte-enable pattern (nbytes lanes wide) to an AXI size code.
  // Single byte -> 1B, aligned contiguous pair -> 2B, everything else -> full width.
  function automatic logic [2:0] be_to_size(input logic [MAX_BE_W-1:0] be,
                                            input int unsigned nbytes);
    int unsigned ones;
    logic        pair;
    logic [2:0]  full_code;
    ones      = 0;
    pair      = 1'b0;
    full_code = SIZE_1B;
    for (int unsigned k = 0; k < 8; k++)
      if ((32'd1 << k) == nbytes) full_code = 3'(k);
    for (int unsigned i = 0; i < MAX_BE_W; i++)
      if (i < nbytes && be[BE_IDX_W'(i)]) ones++;
    for (int unsigned k = 0; k < MAX_BE_W / 2; k++)
      if ((2 * k + 1) < nbytes && be[BE_IDX_W'(2 * k)] && be[BE_IDX_W'(2 * k + 1)]) pair = 1'b1;
    if (ones == nbytes)          return full_code;
    else if (ones == 1)          return SIZE_1B;
    else if (ones == 2 && pair)  return SIZE_2B;
    else                         return full_code;
  endfunction

endpackage

// File: rtl/uncache_wbuf_fifo.sv
// Synchronous FIFO backing the posted-write buffer.
// Ports: clk/rst (sync, active-low), push/din enqueue, pop dequeue,
// head = oldest entry, full/empty status. Push while full and pop while
// empty are ignored.
module uncache_wbuf_fifo #(
  parameter int unsigned W     = 8,
  parameter int unsigned DEPTH = 4
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         push,
  input  logic         pop,
  input  logic [W-1:0] din,
  output logic [W-1:0] head,
  output logic         full,
  output logic         empty
);

  localparam int unsigned PTR_W = $clog2(DEPTH);
  localparam int unsigned CNT_W = PTR_W + 1;

  logic [W-1:0]     mem [DEPTH];
  logic [PTR_W-1:0] wr_ptr;
  logic [PTR_W-1:0] rd_ptr;
  logic [CNT_W-1:0] count;
  logic             do_push;
  logic             do_pop;

  assign full    = (count == CNT_W'(DEPTH));
  assign empty   = (count == '0);
  assign do_push = push & ~full;
  assign do_pop  = pop & ~empty;
  assign head    = mem[rd_ptr];

  // Pointers wrap naturally because DEPTH is a power of two.
  always_ff @(posedge clk) begin
    if (!rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + PTR_W'(1);
      if (do_pop)  rd_ptr <= rd_ptr + PTR_W'(1);
      case ({do_push, do_pop})
        2'b10:   count <= count + CNT_W'(1);
        2'b01:   count <= count - CNT_W'(1);
        default: count <= count;
      endcase
    end
  end

  // Storage needs no reset; count gates every read of it.
  always_ff @(posedge clk) begin
    if (do_push) mem[wr_ptr] <= din;
  end

endmodule

// File: rtl/uncache_wbuf.sv
// Uncached access unit with a posted write buffer.
// Stores go into a FIFO and drain to AXI in order; loads and fences stall
// until the buffer has drained, then loads do a single-beat AXI read.
// Ports: clk/rst (sync, active-low); AXI_* bus side; cpu_* request side;
// cpu_stall (combinational); wb_empty (no buffered or in-flight write).
module uncache_wbuf
  import uncache_pkg::*;
#(
  parameter int unsigned ADDR_W   = 32,
  parameter int unsigned DATA_W   = 32,
  parameter int unsigned WB_DEPTH = 4
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                AXI_rd_dready,
  input  logic                AXI_rd_last,
  input  logic                AXI_rd_addr_clear,
  input  logic [DATA_W-1:0]   AXI_rd_data,
  input  logic                AXI_wr_next,
  input  logic                AXI_wr_ok,
  input  logic                AXI_wr_addr_clear,
  output logic [ADDR_W-1:0]   AXI_addr,
  output logic                AXI_addr_valid,
  output logic                AXI_we,
  output logic                AXI_rd_rready,
  output logic                AXI_wr_dready,
  output logic                AXI_wr_last,
  output logic                AXI_response_rready,
  output logic [2:0]          AXI_size,
  output logic [7:0]          AXI_lens,
  output logic [DATA_W-1:0]   AXI_wr_data,
  output logic [DATA_W/8-1:0] AXI_byte_enable,
  input  logic [ADDR_W-1:0]   cpu_addr,
  input  logic [DATA_W-1:0]   cpu_wrdata,
  input  logic [DATA_W/8-1:0] cpu_byteenable,
  input  logic                cpu_read,
  input  logic                cpu_write,
  input  logic                cpu_new_ins,
  input  logic                cpu_fence,
  output logic [DATA_W-1:0]   cpu_rddata,
  output logic                cpu_stall,
  output logic                wb_empty
);

  localparam int unsigned BE_W    = DATA_W / 8;
  localparam int unsigned ENTRY_W = ADDR_W + DATA_W + BE_W;

  state_t              state;
  logic                done;
  logic [ADDR_W-1:0]   ld_addr;
  logic [BE_W-1:0]     ld_be;
  logic [ENTRY_W-1:0]  fifo_head;
  logic [ADDR_W-1:0]   head_addr;
  logic [DATA_W-1:0]   head_data;
  logic [BE_W-1:0]     head_be;
  logic                fifo_full;
  logic                fifo_empty;
  logic                in_wr;
  logic                push;
  logic                pop;
  logic                load_req;
  logic                fence_req;
  logic                unused_inputs;

  // Single-beat bus, so beat pacing and last-beat flags carry no information.
  assign unused_inputs = AXI_wr_next ^ AXI_rd_last;

  assign in_wr     = (state == ST_WR_REQ) || (state == ST_WR_RESP);
  assign push      = cpu_write & cpu_new_ins;
  assign pop       = in_wr & AXI_wr_ok;
  assign load_req  = cpu_read & cpu_new_ins;
  assign fence_req = cpu_fence & cpu_new_ins;

  uncache_wbuf_fifo #(
    .W     (ENTRY_W),
    .DEPTH (WB_DEPTH)
  ) u_fifo (
    .clk   (clk),
    .rst   (rst),
    .push  (push),
    .pop   (pop),
    .din   ({cpu_addr, cpu_wrdata, cpu_byteenable}),
    .head  (fifo_head),
    .full  (fifo_full),
    .empty (fifo_empty)
  );

  assign {head_addr, head_data, head_be} = fifo_head;

  // Bus payload: head entry while writing, latched load request otherwise.
  assign AXI_addr        = in_wr ? head_addr : ld_addr;
  assign AXI_wr_data     = in_wr ? head_data : '0;
  assign AXI_byte_enable = in_wr ? head_be   : ld_be;
  assign AXI_lens        = 8'd0;

  assign wb_empty  = fifo_empty & ~in_wr;
  // Full is the pre-pop view, so a push meeting a pop waits one cycle.
  assign cpu_stall = cpu_new_ins & ((((cpu_read | cpu_fence) & ~done)) | (cpu_write & fifo_full));

  // Bus sequencing FSM; draining writes always wins over an issued load.
  always_ff @(posedge clk) begin
    if (!rst) begin
      state               <= ST_IDLE;
      done                <= 1'b0;
      AXI_addr_valid      <= 1'b0;
      AXI_we              <= 1'b0;
      AXI_rd_rready       <= 1'b0;
      AXI_wr_dready       <= 1'b0;
      AXI_wr_last         <= 1'b0;
      AXI_response_rready <= 1'b0;
      AXI_size            <= SIZE_1B;
      ld_addr             <= '0;
      ld_be               <= '0;
      cpu_rddata          <= '0;
    end else begin
      done <= 1'b0;
      case (state)
        ST_IDLE: begin
          if (!fifo_empty) begin
            state               <= ST_WR_REQ;
            AXI_we              <= 1'b1;
            AXI_addr_valid      <= 1'b1;
            AXI_wr_dready       <= 1'b1;
            AXI_wr_last         <= 1'b1;
            AXI_response_rready <= 1'b1;
            AXI_size            <= be_to_size(MAX_BE_W'(head_be), BE_W);
          end else if (load_req) begin
            state          <= ST_RD_REQ;
            AXI_we         <= 1'b0;
            AXI_addr_valid <= 1'b1;
            AXI_rd_rready  <= 1'b1;
            ld_addr        <= cpu_addr;
            ld_be          <= cpu_byteenable;
            AXI_size       <= be_to_size(MAX_BE_W'(cpu_byteenable), BE_W);
          end else if (fence_req && !done) begin
            // Buffer drained and bus idle: fence completes for one cycle.
            done <= 1'b1;
          end
        end
        ST_WR_REQ, ST_WR_RESP: begin
          if (AXI_wr_ok) begin
            state               <= ST_IDLE;
            AXI_we              <= 1'b0;
            AXI_addr_valid      <= 1'b0;
            AXI_wr_dready       <= 1'b0;
            AXI_wr_last         <= 1'b0;
            AXI_response_rready <= 1'b0;
          end else if (state == ST_WR_REQ && AXI_wr_addr_clear) begin
            state          <= ST_WR_RESP;
            AXI_addr_valid <= 1'b0;
          end
        end
        ST_RD_REQ: begin
          if (AXI_rd_addr_clear) AXI_addr_valid <= 1'b0;
          if (AXI_rd_dready) begin
            state          <= ST_RD_DONE;
            cpu_rddata     <= AXI_rd_data;
            AXI_addr_valid <= 1'b0;
            AXI_rd_rready  <= 1'b0;
            done           <= 1'b1;
          end
        end
        ST_RD_DONE: state <= ST_IDLE;
        default:    state <= ST_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_uncache_wbuf.sv
// Directed bench for uncache_wbuf: posted stores, full-buffer stall,
// load-after-store ordering, size codes, fence drain and mid-run reset.
module tb_uncache_wbuf;

  localparam int unsigned ADDR_W = 32;
  localparam int unsigned DATA_W = 32;

  logic              clk = 1'b0;
  logic              rst;
  logic              AXI_rd_dready, AXI_rd_last, AXI_rd_addr_clear;
  logic [DATA_W-1:0] AXI_rd_data;
  logic              AXI_wr_next, AXI_wr_ok, AXI_wr_addr_clear;
  logic [ADDR_W-1:0] AXI_addr;
  logic              AXI_addr_valid, AXI_we, AXI_rd_rready, AXI_wr_dready;
  logic              AXI_wr_last, AXI_response_rready;
  logic [2:0]        AXI_size;
  logic [7:0]        AXI_lens;
  logic [DATA_W-1:0] AXI_wr_data;
  logic [3:0]        AXI_byte_enable;
  logic [ADDR_W-1:0] cpu_addr;
  logic [DATA_W-1:0] cpu_wrdata;
  logic [3:0]        cpu_byteenable;
  logic              cpu_read, cpu_write, cpu_new_ins, cpu_fence;
  logic [DATA_W-1:0] cpu_rddata;
  logic              cpu_stall, wb_empty;

  int n_chk = 0;
  int n_bad = 0;

  always #5 clk = ~clk;

  uncache_wbuf #(.ADDR_W(ADDR_W), .DATA_W(DATA_W), .WB_DEPTH(4)) dut (
    .clk                 (clk),
    .rst                 (rst),
    .AXI_rd_dready       (AXI_rd_dready),
    .AXI_rd_last         (AXI_rd_last),
    .AXI_rd_addr_clear   (AXI_rd_addr_clear),
    .AXI_rd_data         (AXI_rd_data),
    .AXI_wr_next         (AXI_wr_next),
    .AXI_wr_ok           (AXI_wr_ok),
    .AXI_wr_addr_clear   (AXI_wr_addr_clear),
    .AXI_addr            (AXI_addr),
    .AXI_addr_valid      (AXI_addr_valid),
    .AXI_we              (AXI_we),
    .AXI_rd_rready       (AXI_rd_rready),
    .AXI_wr_dready       (AXI_wr_dready),
    .AXI_wr_last         (AXI_wr_last),
    .AXI_response_rready (AXI_response_rready),
    .AXI_size            (AXI_size),
    .AXI_lens            (AXI_lens),
    .AXI_wr_data         (AXI_wr_data),
    .AXI_byte_enable     (AXI_byte_enable),
    .cpu_addr            (cpu_addr),
    .cpu_wrdata          (cpu_wrdata),
    .cpu_byteenable      (cpu_byteenable),
    .cpu_read            (cpu_read),
    .cpu_write           (cpu_write),
    .cpu_new_ins         (cpu_new_ins),
    .cpu_fence           (cpu_fence),
    .cpu_rddata          (cpu_rddata),
    .cpu_stall           (cpu_stall),
    .wb_empty            (wb_empty)
  );

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got=0x%0h expected=0x%0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic cpu_idle();
    cpu_read    = 1'b0;
    cpu_write   = 1'b0;
    cpu_fence   = 1'b0;
    cpu_new_ins = 1'b0;
  endtask

  task automatic store(input logic [31:0] a, input logic [31:0] d, input logic [3:0] be,
                       input string tag);
    cpu_addr       = a;
    cpu_wrdata     = d;
    cpu_byteenable = be;
    cpu_write      = 1'b1;
    cpu_new_ins    = 1'b1;
    #1 chk({tag, "_nostall"}, 64'(cpu_stall), 64'h0);
    tick();
    cpu_idle();
  endtask

  task automatic wait_wr(input string tag);
    bit ok;
    ok = 1'b0;
    for (int i = 0; i < 20; i++) begin
      if (AXI_addr_valid && AXI_we) begin
        ok = 1'b1;
        break;
      end
      tick();
    end
    if (!ok) chk({tag, "_wr_timeout"}, 64'h0, 64'h1);
  endtask

  task automatic bus_write(input logic [31:0] a, input logic [31:0] d, input logic [3:0] be,
                           input logic [2:0] sz, input string tag);
    wait_wr(tag);
    chk({tag, "_addr"}, 64'(AXI_addr), 64'(a));
    chk({tag, "_data"}, 64'(AXI_wr_data), 64'(d));
    chk({tag, "_be"},   64'(AXI_byte_enable), 64'(be));
    chk({tag, "_size"}, 64'(AXI_size), 64'(sz));
    AXI_wr_addr_clear = 1'b1;
    tick();
    AXI_wr_addr_clear = 1'b0;
    chk({tag, "_avalid_drop"}, 64'(AXI_addr_valid), 64'h0);
    AXI_wr_ok = 1'b1;
    tick();
    AXI_wr_ok = 1'b0;
    chk({tag, "_we_clear"}, 64'(AXI_we), 64'h0);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    bit ok;
    rst = 1'b0;
    AXI_rd_dready = 1'b0; AXI_rd_last = 1'b0; AXI_rd_addr_clear = 1'b0; AXI_rd_data = '0;
    AXI_wr_next = 1'b0; AXI_wr_ok = 1'b0; AXI_wr_addr_clear = 1'b0;
    cpu_addr = '0; cpu_wrdata = '0; cpu_byteenable = '0;
    cpu_idle();

    // Reset state
    tick();
    tick();
    chk("rst_ctrl", 64'({AXI_addr_valid, AXI_we, AXI_rd_rready, AXI_wr_dready,
                         AXI_wr_last, AXI_response_rready}), 64'h0);
    chk("rst_be",       64'(AXI_byte_enable), 64'h0);
    chk("rst_addr",     64'(AXI_addr), 64'h0);
    chk("rst_wr_data",  64'(AXI_wr_data), 64'h0);
    chk("rst_size",     64'(AXI_size), 64'h0);
    chk("rst_lens",     64'(AXI_lens), 64'h0);
    chk("rst_rddata",   64'(cpu_rddata), 64'h0);
    chk("rst_wb_empty", 64'(wb_empty), 64'h1);
    chk("rst_stall",    64'(cpu_stall), 64'h0);
    rst = 1'b1;
    tick();

    // Three posted stores drain in order
    store(32'h1FD0_0000, 32'h11, 4'hF, "p1");
    chk("avalid_not_yet", 64'(AXI_addr_valid), 64'h0);
    store(32'h1FD0_0004, 32'h22, 4'hF, "p2");
    chk("avalid_one_after_push", 64'(AXI_addr_valid), 64'h1);
    store(32'h1FD0_0008, 32'h33, 4'hF, "p3");
    bus_write(32'h1FD0_0000, 32'h11, 4'hF, 3'd2, "w1");
    bus_write(32'h1FD0_0004, 32'h22, 4'hF, 3'd2, "w2");
    bus_write(32'h1FD0_0008, 32'h33, 4'hF, 3'd2, "w3");
    chk("drain3_empty", 64'(wb_empty), 64'h1);

    // Fifth store against a full buffer
    for (int i = 0; i < 4; i++)
      store(32'h1FD0_0100 + 32'(4 * i), 32'hA0 + 32'(i), 4'hF, "f");
    cpu_addr = 32'h1FD0_0110; cpu_wrdata = 32'hA4; cpu_byteenable = 4'hF;
    cpu_write = 1'b1; cpu_new_ins = 1'b1;
    #1 chk("full_stall", 64'(cpu_stall), 64'h1);
    chk("full_head_s0", 64'(AXI_addr), 64'h1FD0_0100);
    tick();
    chk("full_stall_held", 64'(cpu_stall), 64'h1);
    AXI_wr_ok = 1'b1;
    #1 chk("full_pop_same_cycle", 64'(cpu_stall), 64'h1);
    tick();
    AXI_wr_ok = 1'b0;
    chk("full_accept_next", 64'(cpu_stall), 64'h0);
    tick();
    cpu_idle();
    for (int i = 1; i < 5; i++)
      bus_write(32'h1FD0_0100 + 32'(4 * i), 32'hA0 + 32'(i), 4'hF, 3'd2, "fd");
    chk("full_drain_empty", 64'(wb_empty), 64'h1);

    // Load after store to the same address waits for the write response
    store(32'h1FD0_0010, 32'h1234_5678, 4'hF, "ls");
    cpu_addr = 32'h1FD0_0010; cpu_byteenable = 4'hF;
    cpu_read = 1'b1; cpu_new_ins = 1'b1;
    #1 chk("ld_stall", 64'(cpu_stall), 64'h1);
    wait_wr("ld");
    chk("ld_not_issued", 64'(AXI_rd_rready), 64'h0);
    bus_write(32'h1FD0_0010, 32'h1234_5678, 4'hF, 3'd2, "lw");
    chk("ld_stall_after_ok", 64'(cpu_stall), 64'h1);
    tick();
    chk("ld_issue_ctrl", 64'({AXI_addr_valid, AXI_we, AXI_rd_rready}), 64'h5);
    chk("ld_issue_addr", 64'(AXI_addr), 64'h1FD0_0010);
    chk("ld_issue_size", 64'(AXI_size), 64'h2);
    AXI_rd_addr_clear = 1'b1;
    tick();
    AXI_rd_addr_clear = 1'b0;
    chk("ld_avalid_drop", 64'(AXI_addr_valid), 64'h0);
    chk("ld_stall_wait", 64'(cpu_stall), 64'h1);
    AXI_rd_data = 32'hCAFE_F00D; AXI_rd_dready = 1'b1; AXI_rd_last = 1'b1;
    tick();
    AXI_rd_dready = 1'b0; AXI_rd_last = 1'b0; AXI_rd_data = '0;
    chk("ld_rddata", 64'(cpu_rddata), 64'hCAFE_F00D);
    chk("ld_release", 64'(cpu_stall), 64'h0);
    chk("ld_rready_clear", 64'(AXI_rd_rready), 64'h0);
    cpu_idle();
    tick();
    chk("ld_rddata_held", 64'(cpu_rddata), 64'hCAFE_F00D);

    // Size codes from byte enables
    store(32'h1FD0_0020, 32'h00AB_0000, 4'b0100, "sb");
    bus_write(32'h1FD0_0020, 32'h00AB_0000, 4'b0100, 3'd0, "sbw");
    store(32'h1FD0_0022, 32'hBEEF_0000, 4'b1100, "sh");
    bus_write(32'h1FD0_0022, 32'hBEEF_0000, 4'b1100, 3'd1, "shw");
    store(32'h1FD0_0024, 32'hDEAD_BEEF, 4'b1111, "sw");
    bus_write(32'h1FD0_0024, 32'hDEAD_BEEF, 4'b1111, 3'd2, "sww");

    // Fence over two queued stores; second completes with clear+ok together
    store(32'h1FD0_0030, 32'h30, 4'hF, "fa");
    store(32'h1FD0_0034, 32'h34, 4'hF, "fb");
    cpu_fence = 1'b1; cpu_new_ins = 1'b1;
    #1 chk("fence_stall", 64'(cpu_stall), 64'h1);
    bus_write(32'h1FD0_0030, 32'h30, 4'hF, 3'd2, "fw1");
    chk("fence_hold_mid", 64'(cpu_stall), 64'h1);
    wait_wr("fw2");
    chk("fw2_addr", 64'(AXI_addr), 64'h1FD0_0034);
    AXI_wr_addr_clear = 1'b1; AXI_wr_ok = 1'b1;
    tick();
    AXI_wr_addr_clear = 1'b0; AXI_wr_ok = 1'b0;
    chk("same_cycle_we_clear", 64'(AXI_we), 64'h0);
    chk("same_cycle_empty", 64'(wb_empty), 64'h1);
    ok = 1'b0;
    for (int i = 0; i < 4; i++) begin
      if (!cpu_stall) begin
        ok = 1'b1;
        break;
      end
      tick();
    end
    chk("fence_release", 64'(ok), 64'h1);
    cpu_idle();
    tick();

    // Reset mid-transaction drops buffered writes
    store(32'h1FD0_0040, 32'h40, 4'hF, "ra");
    store(32'h1FD0_0044, 32'h44, 4'hF, "rb");
    rst = 1'b0;
    tick();
    rst = 1'b1;
    chk("rst_mid_empty", 64'(wb_empty), 64'h1);
    chk("rst_mid_ctrl", 64'({AXI_addr_valid, AXI_we}), 64'h0);
    tick();
    tick();
    chk("rst_mid_no_drain", 64'(AXI_addr_valid), 64'h0);

    $display("test done: total=%0d bad=%0d", n_chk, n_bad);
    $finish;
  end

endmodule
